// File: rtl/tlb_ctrl.sv
// rtl/tlb_ctrl.sv - 8-entry TLB controller: associative tag lookup, entry writes, flush walk
// Tags and valid bits live in flops; PTE data lives in an external 8-word RAM.
module tlb_ctrl #(
  parameter int VPN_W = 20,
  parameter int PTE_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lk_req,
  input  logic [VPN_W-1:0] lk_vpn,
  output logic             lk_ack,
  output logic             lk_hit,
  output logic [PTE_W-1:0] lk_pte,
  input  logic             wr_req,
  input  logic             wr_random,
  input  logic [2:0]       wr_index,
  input  logic [VPN_W-1:0] wr_vpn,
  input  logic [PTE_W-1:0] wr_pte,
  output logic             wr_ack,
  output logic [2:0]       wr_used_idx,
  input  logic             flush_req,
  output logic             flush_done,
  output logic             busy,
  output logic [2:0]       ram_addr,
  output logic [PTE_W-1:0] ram_data,
  output logic             ram_we,
  input  logic [PTE_W-1:0] ram_q
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state;
  logic [7:0]       valid;
  logic [VPN_W-1:0] tag [8];
  logic [2:0]       fcnt;
  logic [2:0]       rcnt;
  logic [2:0]       addr_q;

  logic             hit;
  logic [2:0]       match_idx;
  logic [2:0]       wr_idx;
  logic             idle;
  logic             acc_flush;
  logic             acc_wr;
  logic             acc_lk;

  // Scan high to low so the lowest-numbered matching entry wins.
  always_comb begin
    hit       = 1'b0;
    match_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (valid[i] && tag[i] == lk_vpn) begin
        hit       = 1'b1;
        match_idx = 3'(i);
      end
    end
  end

  // A request is never accepted while its own ack is still high.
  assign idle      = (state == IDLE) && !rst;
  assign acc_flush = idle && flush_req && !flush_done;
  assign acc_wr    = idle && !acc_flush && wr_req && !wr_ack;
  assign acc_lk    = idle && !acc_flush && !acc_wr && lk_req && !lk_ack;
  assign wr_idx    = wr_random ? rcnt : wr_index;
  assign busy      = (state == FLUSH);

  always_comb begin
    ram_we   = 1'b0;
    ram_data = '0;
    ram_addr = addr_q;
    if (!rst && state == FLUSH) begin
      ram_we   = 1'b1;
      ram_addr = fcnt;
    end else if (acc_wr) begin
      ram_we   = 1'b1;
      ram_addr = wr_idx;
      ram_data = wr_pte;
    end else if (acc_lk) begin
      ram_addr = match_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      valid       <= '0;
      fcnt        <= 3'd0;
      rcnt        <= 3'd7;
      addr_q      <= 3'd0;
      lk_ack      <= 1'b0;
      lk_hit      <= 1'b0;
      lk_pte      <= '0;
      wr_ack      <= 1'b0;
      wr_used_idx <= 3'd0;
      flush_done  <= 1'b0;
    end else begin
      rcnt       <= rcnt - 3'd1;
      addr_q     <= ram_addr;
      lk_ack     <= acc_lk;
      wr_ack     <= acc_wr;
      flush_done <= 1'b0;
      case (state)
        IDLE: begin
          if (acc_flush) begin
            state <= FLUSH;
            fcnt  <= 3'd0;
          end
          if (acc_wr) begin
            // Drop any duplicate of the new tag so lookups never see two hits.
            for (int i = 0; i < 8; i++) begin
              if (valid[i] && tag[i] == wr_vpn) valid[i] <= 1'b0;
            end
            valid[wr_idx] <= 1'b1;
            tag[wr_idx]   <= wr_vpn;
            wr_used_idx   <= wr_idx;
          end
          if (acc_lk) begin
            lk_hit <= hit;
            lk_pte <= hit ? ram_q : '0;
          end
        end
        FLUSH: begin
          valid[fcnt] <= 1'b0;
          fcnt        <= fcnt + 3'd1;
          if (fcnt == 3'd7) begin
            state      <= IDLE;
            flush_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tlb_ctrl.md
Name: tlb_ctrl

Overview:
- Controller for the 8-entry x 24-bit TLB data RAM: an 8-word array with a combinational read port and a synchronous write port.
- Holds the 8 VPN tags and valid bits in flops and performs fully-associative lookup against them.
- Arbitrates the single RAM address port between translation lookups, indexed/random entry writes and a flush sequencer that walks and zeroes all 8 entries.
- Sits between the MMU request side and the TLB data RAM.

Parameters:
- VPN_W, 20, virtual page number tag width.
- PTE_W, 24, RAM word / page-table-entry width; must match the RAM data width.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, synchronous active-high reset.
- lk_req, in, 1, lookup request; held until lk_ack.
- lk_vpn, in, VPN_W, VPN to translate.
- lk_ack, out, 1, one-cycle pulse; lk_hit and lk_pte are valid in this cycle.
- lk_hit, out, 1, lookup matched a valid entry.
- lk_pte, out, PTE_W, entry data on hit; 0 on miss.
- wr_req, in, 1, entry write request; held until wr_ack.
- wr_random, in, 1, 1 = use the random index, 0 = use wr_index.
- wr_index, in, 3, explicit target entry.
- wr_vpn, in, VPN_W, tag to install.
- wr_pte, in, PTE_W, data to install.
- wr_ack, out, 1, one-cycle pulse; write complete.
- wr_used_idx, out, 3, index actually written; valid with wr_ack.
- flush_req, in, 1, invalidate-all request; held until flush_done.
- flush_done, out, 1, one-cycle pulse at the end of a flush.
- busy, out, 1, high while in FLUSH.
- ram_addr, out, 3, RAM address.
- ram_data, out, PTE_W, RAM write data.
- ram_we, out, 1, RAM write enable.
- ram_q, in, PTE_W, RAM read data (combinational from ram_addr).

Behaviour:
- The clock is clk. Reset is rst, synchronous and active-high.
- Reset state:
  - state = IDLE, all valid bits = 0, flush counter = 0, random counter = 7.
  - All outputs 0; ram_addr = 0, ram_we = 0.
  - Tags and RAM contents are not cleared by reset; valid = 0 masks them.
- Random counter: 3-bit; decrements every cycle outside reset and wraps 0 -> 7.
- States: IDLE, FLUSH.
- IDLE arbitration, fixed priority flush > write > lookup. At most one request is accepted per cycle.
- Re-accept guard: a request type is not accepted in a cycle in which its own ack (lk_ack, wr_ack or flush_done) is high. This prevents double acceptance while the requester drops req.
- Lookup, accepted in IDLE:
  - Compare lk_vpn against all valid tags.
  - Match index = lowest-numbered matching valid entry.
  - Drive ram_addr = match index (0 on miss) and ram_we = 0.
  - Register lk_hit and lk_pte (ram_q on hit, 0 on miss).
  - lk_ack is high the next cycle, so latency is 1.
  - lk_hit and lk_pte hold their values until the next lookup ack.
- Write, accepted in IDLE:
  - idx = wr_random ? random counter : wr_index.
  - Drive ram_addr = idx, ram_data = wr_pte, ram_we = 1 for exactly that cycle.
  - On the same edge: tag[idx] <= wr_vpn, valid[idx] <= 1.
  - Any other valid entry whose tag equals wr_vpn gets valid <= 0, so tags stay unique.
  - wr_ack and wr_used_idx = idx are driven the next cycle.
- Flush, accepted in IDLE:
  - Enter FLUSH with counter = 0; busy is high from the next cycle.
  - Each FLUSH cycle: ram_addr = counter, ram_data = 0, ram_we = 1, valid[counter] <= 0, counter++.
  - After the counter = 7 cycle, return to IDLE; flush_done pulses in the first IDLE cycle.
  - FLUSH therefore lasts exactly 8 cycles.
  - No lookup or write is accepted during FLUSH; those requests stay pending.
- Write and lookup arriving in the same cycle: the write is served first and the lookup the following cycle. The lookup therefore sees the newly written entry.
- Reset mid-flush: return to IDLE immediately, all valid = 0, no flush_done. Partially zeroed RAM is acceptable.
- In idle cycles ram_we = 0 and ram_addr holds its last value.

Test Plan:
1. Reset, then lookup vpn 0x12345 -> lk_ack 1 cycle later, lk_hit = 0, lk_pte = 0.
2. Indexed write idx 3, vpn 0x12345, pte 0xABCDEF -> ram_we pulse with addr 3, wr_ack next cycle with wr_used_idx = 3. Lookup vpn 0x12345 -> lk_hit = 1, lk_pte = 0xABCDEF.
3. Write vpn 0x00001 to idx 2, then the same vpn to idx 5 -> entry 2 invalidated. Lookup returns the idx 5 data; a second write of different data to idx 5 is returned on the next lookup.
4. Random write 3 cycles after reset -> wr_used_idx = 4. Lookup hits with the written pte.
5. Fill all 8 entries, assert flush_req with lk_req held high -> busy for 8 cycles, ram_we high with addresses 0..7 and data 0, flush_done pulse. The lookup is acked only after that and misses.
6. Assert rst at the 4th flush cycle -> IDLE next cycle, no flush_done, busy = 0. Subsequent lookup of a previously written vpn misses.
